// File: rtl/line_fill_ctrl.sv
`default_nettype none
// ============================================================================
// line_fill_ctrl -- serialises cache line refills and write-through stores
// onto the single main-memory port.   Revision: 1.0
// ============================================================================
module line_fill_ctrl #(
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = 32,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fill_req,
  input  logic              wt_req,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] wt_data,
  output logic              busy,
  output logic              done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              cache_we,
  output logic [ADDR_W-1:0] cache_addr,
  output logic [DATA_W-1:0] cache_wdata,
  output logic              tag_we
);

  localparam int OFF_W = $clog2(WORDS_PER_LINE);
  localparam logic [OFF_W-1:0] c_LAST_OFF = OFF_W'(WORDS_PER_LINE - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FILL_RD = 3'd1,
    ST_TAG_UPD = 3'd2,
    ST_WT      = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic [OFF_W-1:0]  r_off;

  logic [ADDR_W-1:0] w_line_base;
  logic [ADDR_W-1:0] w_fill_addr;
  logic              w_off_last;
  logic              w_accept;

  // Offset replaces the low bits outright, so the tag/index bits never see a carry.
  assign w_line_base = {r_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign w_fill_addr = {r_addr[ADDR_W-1:OFF_W], r_off};
  assign w_off_last  = (r_off == c_LAST_OFF);
  assign w_accept    = (r_state == ST_IDLE) && (wt_req || fill_req);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_data  <= '0;
      r_off   <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_addr <= req_addr;
        r_data <= wt_data;
        r_off  <= '0;
      end else if ((r_state == ST_FILL_RD) && mem_ack && !w_off_last) begin
        r_off <= r_off + 1'b1;
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    cache_we     = 1'b0;
    cache_addr   = '0;
    cache_wdata  = '0;
    tag_we       = 1'b0;

    case (r_state)
      ST_IDLE: begin
        // Write-through first so the store lands in RAM before any refill reads it.
        if (wt_req) begin
          w_next_state = ST_WT;
        end else if (fill_req) begin
          w_next_state = ST_FILL_RD;
        end
      end

      ST_FILL_RD: begin
        busy     = 1'b1;
        mem_req  = 1'b1;
        mem_addr = w_fill_addr;
        if (mem_ack) begin
          cache_we    = 1'b1;
          cache_addr  = w_fill_addr;
          cache_wdata = mem_rdata;
          if (w_off_last) begin
            w_next_state = ST_TAG_UPD;
          end
        end
      end

      ST_TAG_UPD: begin
        busy         = 1'b1;
        tag_we       = 1'b1;
        cache_addr   = w_line_base;
        w_next_state = ST_DONE;
      end

      ST_WT: begin
        busy      = 1'b1;
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = r_addr;
        mem_wdata = r_data;
        if (mem_ack) begin
          w_next_state = ST_DONE;
        end
      end

      ST_DONE: begin
        busy         = 1'b1;
        done         = 1'b1;
        w_next_state = ST_IDLE;
      end

      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_line_fill_ctrl.sv
`default_nettype none
// ============================================================================
// tb_line_fill_ctrl -- vector table plus scoreboard bench for line_fill_ctrl.
// Revision: 1.0
// ============================================================================
module tb_line_fill_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fill_req = 1'b0;
  logic        wt_req = 1'b0;
  logic [15:0] req_addr = '0;
  logic [31:0] wt_data = '0;
  logic        busy, done, mem_req, mem_we, mem_ack, cache_we, tag_we;
  logic [15:0] mem_addr, cache_addr;
  logic [31:0] mem_wdata, mem_rdata, cache_wdata;

  // Memory model: acks after `delay` wait cycles, data = rbase + word offset.
  int          delay = 0;
  int          wcnt = 0;
  logic [31:0] rbase = '0;
  logic        force_ack = 1'b0;
  assign mem_ack   = force_ack | (mem_req && (wcnt == delay));
  assign mem_rdata = rbase + {30'd0, mem_addr[1:0]};

  line_fill_ctrl dut (
    .clk(clk), .reset(reset), .fill_req(fill_req), .wt_req(wt_req),
    .req_addr(req_addr), .wt_data(wt_data), .busy(busy), .done(done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .cache_we(cache_we), .cache_addr(cache_addr),
    .cache_wdata(cache_wdata), .tag_we(tag_we)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [31:0] wdata;
  } mem_t;

  typedef struct packed {
    logic [15:0] addr;
    logic [31:0] data;
  } cw_t;

  typedef struct {
    logic        wt;
    logic [15:0] addr;
    logic [31:0] data;
    logic [31:0] rbase;
    int          delay;
    int          lat;
  } vec_t;

  mem_t        mem_q[$];
  cw_t         cw_q[$];
  logic [15:0] tag_q[$];

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          done_cnt = 0;
  int          done_cyc = 0;
  int          busy_cyc = 0;
  logic        prev_busy = 1'b0;
  logic        prev_req = 1'b0;
  logic        prev_ack = 1'b0;
  logic [48:0] prev_mem = '0;

  function automatic void check(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void unexpected(input string name);
    total++;
    bad++;
    $display("FAIL %s: event seen, required none (cycle %0d)", name, cyc);
  endfunction

  task automatic monitor();
    mem_t m;
    cw_t  c;
    if (mem_req && mem_ack) begin
      if (mem_q.size() == 0) unexpected("mem_txn");
      else begin
        m = mem_q.pop_front();
        check("mem_we", 64'(mem_we), 64'(m.we));
        check("mem_addr", 64'(mem_addr), 64'(m.addr));
        if (m.we) check("mem_wdata", 64'(mem_wdata), 64'(m.wdata));
      end
    end
    if (cache_we) begin
      if (cw_q.size() == 0) unexpected("cache_we");
      else begin
        c = cw_q.pop_front();
        check("cache_addr", 64'(cache_addr), 64'(c.addr));
        check("cache_wdata", 64'(cache_wdata), 64'(c.data));
      end
    end
    if (tag_we) begin
      if (tag_q.size() == 0) unexpected("tag_we");
      else check("tag_addr", 64'(cache_addr), 64'(tag_q.pop_front()));
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (busy && !prev_busy) busy_cyc = cyc;
    // Request fields must hold steady through every wait cycle.
    if (prev_req && !prev_ack && !reset)
      check("mem_hold", 64'({mem_req, mem_we, mem_addr, mem_wdata}), 64'({1'b1, prev_mem}));
    prev_busy = busy;
    prev_req  = mem_req;
    prev_ack  = mem_ack;
    prev_mem  = {mem_we, mem_addr, mem_wdata};
  endtask

  task automatic tick();
    int   nxt;
    logic drop;
    @(negedge clk);
    cyc++;
    monitor();
    nxt  = (mem_req && !mem_ack) ? wcnt + 1 : 0;
    drop = done;
    @(posedge clk);
    #1;
    wcnt = nxt;
    if (drop) begin
      if (wt_req) wt_req = 1'b0;
      else fill_req = 1'b0;
    end
  endtask

  task automatic check_zero(input string name);
    check({name, "_ctrl"}, 64'({busy, done, mem_req, mem_we, cache_we, tag_we}), 64'(0));
    check({name, "_addr"}, 64'({mem_addr, cache_addr}), 64'(0));
    check({name, "_data"}, {mem_wdata, cache_wdata}, 64'(0));
  endtask

  task automatic push_fill(input logic [15:0] addr, input logic [31:0] rb, input int words);
    logic [15:0] base;
    base = addr & 16'hFFFC;
    for (int o = 0; o < words; o++) begin
      mem_q.push_back('{we: 1'b0, addr: base | 16'(o), wdata: 32'd0});
      cw_q.push_back('{addr: base | 16'(o), data: rb + 32'(o)});
    end
    if (words == 4) tag_q.push_back(base);
  endtask

  task automatic run_vec(input vec_t v);
    int t0, d0, n;
    delay = v.delay;
    rbase = v.rbase;
    if (v.wt) mem_q.push_back('{we: 1'b1, addr: v.addr, wdata: v.data});
    else push_fill(v.addr, v.rbase, 4);
    req_addr = v.addr;
    wt_data  = v.data;
    wt_req   = v.wt;
    fill_req = !v.wt;
    t0 = cyc + 1;
    d0 = done_cnt;
    n  = 0;
    while (done_cnt == d0 && n < 200) begin
      tick();
      req_addr = 16'($urandom);
      wt_data  = $urandom;
      n++;
    end
    check("done_latency", 64'(done_cyc - t0), 64'(v.lat));
    check("accept_busy", 64'(busy_cyc - t0), 64'(1));
    check("sb_empty", 64'(mem_q.size() + cw_q.size() + tag_q.size()), 64'(0));
    tick();
    tick();
  endtask

  vec_t vecs[6];

  initial begin
    int d0, t0, n;
    vecs[0] = '{1'b0, 16'h1236, 32'h0,        32'h0000_00A0, 0, 6};
    vecs[1] = '{1'b0, 16'h4321, 32'h0,        32'h1111_0000, 3, 18};
    vecs[2] = '{1'b1, 16'h00FF, 32'hDEADBEEF, 32'h0,         2, 4};
    vecs[3] = '{1'b1, 16'hABCD, 32'h0123_4567, 32'h0,        0, 2};
    vecs[4] = '{1'b0, 16'hFFFF, 32'h0,        32'hC0DE_0000, 1, 10};
    vecs[5] = '{1'b0, 16'h0000, 32'h0,        32'h5A5A_0000, 0, 6};

    // Reset with ack toggling and no requests.
    for (int i = 0; i < 6; i++) begin
      force_ack = ~force_ack;
      if (i == 3) reset = 1'b0;
      tick();
      check_zero("reset_idle");
    end
    force_ack = 1'b0;
    check("reset_no_done", 64'(done_cnt), 64'(0));

    foreach (vecs[i]) run_vec(vecs[i]);

    // Both requests rise together: write-through, then refill.
    delay = 0;
    rbase = 32'h7700_0000;
    mem_q.push_back('{we: 1'b1, addr: 16'h3335, wdata: 32'hCAFE_F00D});
    push_fill(16'h3335, rbase, 4);
    req_addr = 16'h3335;
    wt_data  = 32'hCAFE_F00D;
    wt_req   = 1'b1;
    fill_req = 1'b1;
    t0 = cyc + 1;
    d0 = done_cnt;
    n  = 0;
    while (done_cnt < d0 + 2 && n < 200) begin
      tick();
      n++;
    end
    check("both_done_count", 64'(done_cnt - d0), 64'(2));
    check("both_latency", 64'(done_cyc - t0), 64'(9));
    check("both_sb_empty", 64'(mem_q.size() + cw_q.size() + tag_q.size()), 64'(0));
    tick();
    tick();

    // Reset after the second word of a refill.
    delay = 0;
    rbase = 32'h0000_00B0;
    push_fill(16'h2002, rbase, 2);
    req_addr = 16'h2002;
    fill_req = 1'b1;
    n = 0;
    while (cw_q.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    check("mid_words_seen", 64'(cw_q.size() + mem_q.size()), 64'(0));
    #1;
    reset    = 1'b1;
    fill_req = 1'b0;
    #1;
    check_zero("mid_reset");
    d0 = done_cnt;
    repeat (3) tick();
    check("mid_no_done", 64'(done_cnt - d0), 64'(0));
    reset = 1'b0;
    tick();
    run_vec('{1'b0, 16'h2002, 32'h0, 32'h0000_00C0, 0, 6});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/line_fill_ctrl.md
# line_fill_ctrl

Sequencer between the cache control FSM and the single main-memory port. It serialises two kinds of memory work onto that port: line refills on a read or write miss, and single-word write-through stores on a write hit. For a refill it reads every word of the missing line from RAM, writes each word into the cache data array, then updates the tag/valid entry. It gives the cache FSM one level request / one-cycle `done` handshake per operation.

## Interface
Parameters:
- `ADDR_W`, 16, word-address width
- `DATA_W`, 32, data word width
- `WORDS_PER_LINE`, 4, words per cache line; power of 2, ≥2
- `OFF_W`, $clog2(WORDS_PER_LINE), word-offset width (derived, not overridden)

Ports:
- `clk`  in  1  clock
- `reset`  in  1  asynchronous, active-high
- `fill_req`  in  1  refill request; held by requester until `done`
- `wt_req`  in  1  write-through request; held by requester until `done`
- `req_addr`  in  ADDR_W  word address of the request; sampled at acceptance
- `wt_data`  in  DATA_W  store data; sampled at acceptance
- `busy`  out  1  operation in progress
- `done`  out  1  one-cycle pulse; operation complete
- `mem_req`  out  1  memory transaction request
- `mem_we`  out  1  1 = write, 0 = read; valid while `mem_req`=1
- `mem_addr`  out  ADDR_W  memory word address
- `mem_wdata`  out  DATA_W  memory write data
- `mem_ack`  in  1  one-cycle completion from memory; read data valid in the same cycle
- `mem_rdata`  in  DATA_W  memory read data
- `cache_we`  out  1  cache data-array word write enable
- `cache_addr`  out  ADDR_W  cache word address (line base + offset)
- `cache_wdata`  out  DATA_W  cache write data
- `tag_we`  out  1  one-cycle pulse: write tag and set valid for the line at `cache_addr`

## Operation
- States: IDLE, FILL_RD, TAG_UPD, WT, DONE.
- IDLE: `busy`=0. Requests are sampled only here. If `wt_req`=1, go to WT; else if `fill_req`=1, go to FILL_RD. When both are high, write-through wins, so the store reaches RAM before any refill reads it. On acceptance, latch `req_addr`, latch `wt_data`, clear the offset counter.
- Line base is the latched address with its low OFF_W bits cleared. A refill always starts at offset 0 and increments; there is no critical-word-first ordering.
- FILL_RD: `mem_req`=1, `mem_we`=0, `mem_addr` = base | offset. On `mem_ack`, in the same cycle: `cache_we`=1, `cache_wdata`=`mem_rdata`, `cache_addr`=`mem_addr`.
  - If offset = WORDS_PER_LINE−1, go to TAG_UPD.
  - Otherwise increment offset and stay in FILL_RD. `mem_req` stays high with the next address.
- TAG_UPD: `tag_we`=1 for one cycle, `cache_addr` = line base; then go to DONE.
- WT: `mem_req`=1, `mem_we`=1, `mem_addr` = latched address, `mem_wdata` = latched data; hold until `mem_ack`, then go to DONE. The cache array is not written here; the cache FSM writes the hit word itself.
- DONE: `done`=1 for one cycle, then go to IDLE. A request still high in IDLE is treated as a new request; requesters must drop the request on `done`.
- `busy`=1 in every state except IDLE.
- `mem_ack` outside FILL_RD or WT is ignored.
- Offset counter is OFF_W bits and never wraps inside an operation. Address arithmetic has no carry into the tag/index bits.
- Changes on `req_addr`, `wt_data` or the request lines while `busy`=1 have no effect.

## Timing
- Reset value of every output is 0. State goes to IDLE, offset to 0, latches to 0.
- Reset mid-operation: outputs drop on the next evaluation after `reset` asserts. No `tag_we` or `done` is issued. A partially written line stays invalid.
- Acceptance: request high at edge k → `busy`=1 and `mem_req`=1 from cycle k+1.
- `mem_req`, `mem_we`, `mem_addr` and `mem_wdata` are stable from assertion until the cycle containing `mem_ack`.
- Refill with memory acking in the first cycle of each request: WORDS_PER_LINE cycles in FILL_RD, then 1 cycle TAG_UPD, then 1 cycle DONE. With defaults, `done` is in cycle k+6.
- Write-through with immediate ack: `done` in cycle k+2.
- An ack delay of W cycles per word adds W cycles per word.
- Outputs are Moore outputs from registered state, except `cache_we`, `cache_wdata` and `cache_addr` in FILL_RD, which follow `mem_ack`/`mem_rdata` combinationally.

## Test plan
- Reset/idle:
  - Stimulus: `reset` pulsed with `mem_ack` toggling and no requests.
  - Required response: all outputs 0, `busy`=0, no `done`.
- Refill, zero wait:
  - Stimulus: `fill_req` with `req_addr`=0x1236; memory returns 0xA0..0xA3 with ack in the first cycle of each request.
  - Required response: `mem_addr` sequence 0x1234, 0x1235, 0x1236, 0x1237; `cache_we` with data 0xA0..0xA3; `tag_we` at `cache_addr` 0x1234; `done` in cycle k+6.
- Refill, wait states:
  - Stimulus: ack delayed 3 cycles per word.
  - Required response: `mem_req` and `mem_addr` stable during every wait; exactly 4 `cache_we` pulses; `done` in cycle k+18.
- Write-through:
  - Stimulus: `wt_req`, `req_addr`=0x00FF, `wt_data`=0xDEADBEEF, ack after 2 cycles.
  - Required response: `mem_we`=1 with address and data held; no `cache_we` or `tag_we`; `done` one cycle after ack.
- Simultaneous requests:
  - Stimulus: `fill_req` and `wt_req` both rise in the same cycle.
  - Required response: write-through completes first; the refill starts after the return to IDLE; one `done` per operation.
- Reset mid-refill:
  - Stimulus: `reset` asserted after the 2nd word's ack.
  - Required response: outputs 0 immediately; no `tag_we`; a new refill after reset starts at offset 0.
